// File: rtl/seq_masked_reduce_or.sv
// Multi-cycle OR reduction of a wide vector with per-bit constant overrides.
// Constant bits (in_msk=1) contribute in_val; other bits contribute in_a.
// Constant ones, fully masked operands and a hit in chunk 0 resolve in the
// accept cycle. Otherwise the remaining chunks are scanned CHUNK bits per
// cycle, and the scan stops at the first set bit. The result is held on a
// valid/ready output until the consumer takes it.
module seq_masked_reduce_or #(
    parameter int A_WIDTH = 16,
    parameter int CHUNK   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [A_WIDTH-1:0] in_msk,
    input  logic [A_WIDTH-1:0] in_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_y,
    output logic               out_early
);

    localparam int NCHUNK = (A_WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDX_W  = $clog2(NCHUNK + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [A_WIDTH-1:0] LOW_MASK = {A_WIDTH{1'b1}} >> (A_WIDTH - CHUNK);
    // A hit in chunk 0 is early only when more chunks exist behind it.
    localparam logic EARLY0 = (NCHUNK > 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]     idx_r, idx_nxt_s;
    logic [A_WIDTH-1:0]   a_r, a_nxt_s;
    logic                 y_r, y_nxt_s;
    logic                 early_r, early_nxt_s;
    logic                 valid_r;

    logic [A_WIDTH-1:0]   in_eff_s;
    logic                 const_one_s;
    logic                 all_msk_s;
    logic                 in_hit_s;
    logic [A_WIDTH-1:0]   shifted_s;
    logic                 scan_hit_s;

    // Operand decode and chunk selection. Shifting right brings in zeros,
    // so positions past A_WIDTH in the last chunk read as 0.
    always_comb begin
        in_eff_s    = in_a & ~in_msk;
        const_one_s = |(in_msk & in_val);
        all_msk_s   = &in_msk;
        in_hit_s    = |(in_eff_s & LOW_MASK);
        shifted_s   = a_r >> (int'(idx_r) * CHUNK);
        scan_hit_s  = |(shifted_s & LOW_MASK);
    end

    // Next-state and result logic.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        a_nxt_s     = a_r;
        y_nxt_s     = y_r;
        early_nxt_s = early_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_nxt_s   = in_eff_s;
                    idx_nxt_s = '0;
                    if (const_one_s) begin
                        state_nxt_s = DONE;
                        y_nxt_s     = 1'b1;
                        early_nxt_s = 1'b1;
                    end else if (all_msk_s) begin
                        state_nxt_s = DONE;
                        y_nxt_s     = 1'b0;
                        early_nxt_s = 1'b0;
                    end else if (in_hit_s) begin
                        state_nxt_s = DONE;
                        y_nxt_s     = 1'b1;
                        early_nxt_s = EARLY0;
                    end else if (NCHUNK == 1) begin
                        state_nxt_s = DONE;
                        y_nxt_s     = 1'b0;
                        early_nxt_s = 1'b0;
                    end else begin
                        // Chunk 0 was checked in the accept cycle.
                        state_nxt_s = SCAN;
                        idx_nxt_s   = IDX_W'(1);
                        y_nxt_s     = 1'b0;
                        early_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_hit_s) begin
                    state_nxt_s = DONE;
                    y_nxt_s     = 1'b1;
                    early_nxt_s = (idx_r != LAST_IDX);
                end else if (idx_r == LAST_IDX) begin
                    state_nxt_s = DONE;
                    y_nxt_s     = 1'b0;
                    early_nxt_s = 1'b0;
                end else begin
                    idx_nxt_s = idx_r + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, operand and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            y_r     <= 1'b0;
            early_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            a_r     <= a_nxt_s;
            y_r     <= y_nxt_s;
            early_r <= early_nxt_s;
            valid_r <= (state_nxt_s == DONE);
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = valid_r;
    assign out_y     = y_r;
    assign out_early = early_r;

endmodule

// File: tb/tb_seq_masked_reduce_or.sv
// Self-checking bench for seq_masked_reduce_or: a 16-bit/4-bit instance for
// most scenarios and a 10-bit/4-bit instance for the partial last chunk.
module tb_seq_masked_reduce_or;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, out_y, out_early;
    logic [15:0] in_a, in_msk, in_val;

    logic        in_valid10, in_ready10, out_valid10, out_ready10, out_y10, out_early10;
    logic [9:0]  in_a10, in_msk10, in_val10;

    seq_masked_reduce_or #(.A_WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_msk(in_msk), .in_val(in_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_early(out_early)
    );

    seq_masked_reduce_or #(.A_WIDTH(10), .CHUNK(4)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_a(in_a10), .in_msk(in_msk10), .in_val(in_val10),
        .out_valid(out_valid10), .out_ready(out_ready10),
        .out_y(out_y10), .out_early(out_early10)
    );

    typedef struct {
        logic y;
        logic e;
        int   lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] m;
        logic [15:0] v;
        logic        y;
        logic        e;
        int          lat;
    } op_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Present one operand for the accept edge and record its expected result.
    task automatic start16(input logic [15:0] a, input logic [15:0] m, input logic [15:0] v,
                           input logic ey, input logic ee, input int el);
        exp_t x;
        x.y = ey; x.e = ee; x.lat = el;
        sb.push_back(x);
        in_a = a; in_msk = m; in_val = v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom); in_msk = 16'($urandom); in_val = 16'($urandom);
    endtask

    // Count edges from accept until out_valid (bounded; -1 on timeout).
    task automatic wait16(output logic y, output logic e, output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        y = out_y;
        e = out_early;
    endtask

    task automatic release16();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, out_y, out_early} !== 4'b1000) begin
            $display("FAIL reset16: got rdy/vld/y/early=%b want 1000",
                     {in_ready, out_valid, out_y, out_early});
        end else passes++;
        checks++;
        if ({in_ready10, out_valid10, out_y10, out_early10} !== 4'b1000) begin
            $display("FAIL reset10: got rdy/vld/y/early=%b want 1000",
                     {in_ready10, out_valid10, out_y10, out_early10});
        end else passes++;
    endtask

    task automatic test_reset_mid_scan();
        int   stray = 0;
        logic y, e;
        int   lat;
        exp_t x;
        in_a = 16'h0000; in_msk = 16'h0000; in_val = 16'h0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL mid_scan_reset: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            $display("FAIL stray_result: got %0d valid cycles want 0", stray);
        end else passes++;
        start16(16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1);
        wait16(y, e, lat);
        x = sb.pop_front();
        checks++;
        if (y !== x.y || e !== x.e || lat != x.lat) begin
            $display("FAIL after_reset_op: got y=%b e=%b lat=%0d want y=%b e=%b lat=%0d",
                     y, e, lat, x.y, x.e, x.lat);
        end else passes++;
        release16();
    endtask

    task automatic test_patterns();
        op_t ops[9] = '{
            '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1},
            '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 4},
            '{16'h0F00, 16'h0000, 16'h0000, 1'b1, 1'b1, 3},
            '{16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b1, 3},
            '{16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4},
            '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1},
            '{16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 4},
            '{16'h0030, 16'h0000, 16'h0000, 1'b1, 1'b1, 2},
            '{16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1}
        };
        logic y, e;
        int   lat;
        exp_t x;
        for (int i = 0; i < 9; i++) begin
            start16(ops[i].a, ops[i].m, ops[i].v, ops[i].y, ops[i].e, ops[i].lat);
            wait16(y, e, lat);
            x = sb.pop_front();
            checks++;
            if (y !== x.y || e !== x.e || lat != x.lat) begin
                $display("FAIL pattern%0d: got y=%b e=%b lat=%0d want y=%b e=%b lat=%0d",
                         i, y, e, lat, x.y, x.e, x.lat);
            end else passes++;
            release16();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL pattern%0d_release: got vld=%b rdy=%b want vld=0 rdy=1",
                         i, out_valid, in_ready);
            end else passes++;
        end
    endtask

    task automatic test_partial();
        logic [9:0] pa[4]  = '{10'h200, 10'h001, 10'h000, 10'h020};
        logic       py[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       pe[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        int         pl[4]  = '{3, 1, 3, 2};
        int   lat;
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            x.y = py[i]; x.e = pe[i]; x.lat = pl[i];
            sb.push_back(x);
            in_a10 = pa[i]; in_msk10 = 10'h000; in_val10 = 10'h3FF; in_valid10 = 1'b1;
            @(posedge clk); #1;
            in_valid10 = 1'b0;
            lat = 1;
            while (!out_valid10 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            if (!out_valid10) lat = -1;
            x = sb.pop_front();
            checks++;
            if (out_y10 !== x.y || out_early10 !== x.e || lat != x.lat) begin
                $display("FAIL partial%0d: got y=%b e=%b lat=%0d want y=%b e=%b lat=%0d",
                         i, out_y10, out_early10, lat, x.y, x.e, x.lat);
            end else passes++;
            out_ready10 = 1'b1;
            @(posedge clk); #1;
            out_ready10 = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic y, e;
        int   lat;
        int   bad = 0;
        exp_t x;
        start16(16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b1, 3);
        wait16(y, e, lat);
        x = sb.pop_front();
        checks++;
        if (y !== x.y || e !== x.e || lat != x.lat) begin
            $display("FAIL bp_result: got y=%b e=%b lat=%0d want y=%b e=%b lat=%0d",
                     y, e, lat, x.y, x.e, x.lat);
        end else passes++;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_y !== x.y || out_early !== x.e || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            $display("FAIL bp_hold: got %0d bad held cycles want 0", bad);
        end else passes++;
        release16();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end else passes++;
    endtask

    task automatic test_back_to_back();
        op_t ops[3] = '{
            '{16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1},
            '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4},
            '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1}
        };
        int   k = 0;
        int   nres = 0;
        int   overlap = 0;
        logic acc;
        exp_t x;
        in_a = ops[0].a; in_msk = ops[0].m; in_val = ops[0].v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            acc = in_ready && in_valid;
            if (in_ready && out_valid) overlap++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL b2b_extra: got unexpected result y=%b want none", out_y);
                end else begin
                    x = sb.pop_front();
                    checks++;
                    if (out_y !== x.y || out_early !== x.e) begin
                        $display("FAIL b2b_result%0d: got y=%b e=%b want y=%b e=%b",
                                 nres, out_y, out_early, x.y, x.e);
                    end else passes++;
                end
                nres++;
            end
            if (acc) begin
                x.y = ops[k].y; x.e = ops[k].e; x.lat = ops[k].lat;
                sb.push_back(x);
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 3) begin
                    in_a = ops[k].a; in_msk = ops[k].m; in_val = ops[k].v;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nres != 3 || k != 3 || overlap != 0) begin
            $display("FAIL b2b_count: got results=%0d accepts=%0d overlap=%0d want 3 3 0",
                     nres, k, overlap);
        end else passes++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_a = 16'h0000; in_msk = 16'h0000; in_val = 16'h0000;
        in_valid10 = 1'b0; out_ready10 = 1'b0;
        in_a10 = 10'h000; in_msk10 = 10'h000; in_val10 = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset_mid_scan();
        test_patterns();
        test_partial();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
